// File: rtl/noc_sync_pkg.sv
// Shared types for the synchronous NoC merge/split datapath.
// Flit layout: MSB is the tail flag, remaining bits are payload.
package noc_sync_pkg;

  localparam int FLIT_W = 9;

  typedef logic [FLIT_W-1:0] flit_t;

  typedef enum logic [1:0] {
    IDLE,
    LOCK0,
    LOCK1
  } arb_state_t;

  function automatic logic tail(input flit_t f);
    return f[FLIT_W-1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; empty head reads as zero.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    if (push_i) wr_d = wr_q + AW'(1);
    if (pop_i)  rd_d = rd_q + AW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/merge2_sync.sv
// Two-input packet merge: packet-granular round-robin onto one
// link, each output flit tagged with the input it came from.
module merge2_sync #(
  parameter int FLIT_W = noc_sync_pkg::FLIT_W,
  parameter int DEPTH  = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [FLIT_W-1:0] In0_data,
  input  logic              In0_valid,
  output logic              In0_ready,
  input  logic [FLIT_W-1:0] In1_data,
  input  logic              In1_valid,
  output logic              In1_ready,
  output logic [FLIT_W-1:0] Out_data,
  output logic              Out_sel,
  output logic              Out_valid,
  input  logic              Out_ready
);

  import noc_sync_pkg::*;

  arb_state_t state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] grant_q, grant_d;

  logic            fifo_empty, fifo_full;
  logic            push, pop, can_push;
  logic            xfer0, xfer1, tail0, tail1;
  logic [FLIT_W:0] fifo_din, fifo_dout;

  assign pop      = !fifo_empty && Out_ready;
  assign can_push = !fifo_full || pop;

  assign In0_ready = grant_q[0] && can_push && !RESET;
  assign In1_ready = grant_q[1] && can_push && !RESET;

  assign xfer0 = In0_valid && In0_ready;
  assign xfer1 = In1_valid && In1_ready;
  assign tail0 = In0_data[FLIT_W-1];
  assign tail1 = In1_data[FLIT_W-1];

  assign push     = xfer0 || xfer1;
  assign fifo_din = xfer1 ? {1'b1, In1_data}
                          : {1'b0, In0_data};

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = '0;
    unique case (state_q)
      IDLE: begin
        if (xfer0) begin
          if (tail0) last_d  = 1'b0;
          else       state_d = LOCK0;
        end else if (xfer1) begin
          if (tail1) last_d  = 1'b1;
          else       state_d = LOCK1;
        end
      end
      LOCK0: begin
        if (xfer0 && tail0) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end
      end
      LOCK1: begin
        if (xfer1 && tail1) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Grant for next cycle follows the lock, else re-arbitrates
    unique case (state_d)
      LOCK0: grant_d = 2'b01;
      LOCK1: grant_d = 2'b10;
      default: begin
        if (In0_valid && In1_valid)
          grant_d = last_d ? 2'b01 : 2'b10;
        else
          grant_d = {In1_valid, In0_valid};
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
    end
  end

  sync_fifo #(
    .W     (FLIT_W + 1),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign Out_valid           = !fifo_empty;
  assign {Out_sel, Out_data} = fifo_dout;

endmodule

// File: tb/tb_merge2_sync.sv
// Scoreboard bench for merge2_sync: per-source order, packet
// contiguity, select tagging, buffering and reset behaviour.
module tb_merge2_sync;

  localparam int FW    = 9;
  localparam int DEPTH = 2;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic [FW-1:0] In0_data, In1_data, Out_data;
  logic          In0_valid, In0_ready;
  logic          In1_valid, In1_ready;
  logic          Out_sel, Out_valid;
  logic          Out_ready = 1'b0;

  logic          v [2] = '{1'b0, 1'b0};
  logic [FW-1:0] d [2] = '{9'h0, 9'h0};
  logic          hs [2] = '{1'b0, 1'b0};
  logic          open_in [2] = '{1'b0, 1'b0};

  logic [FW-1:0] pend [2][$];
  logic [FW-1:0] expq [2][$];
  logic [FW:0]   log_q [$];
  int            log_c [$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   occ = 0;
  int   omode = 0;
  int   vprob = 100;
  int   r1_cnt = 0;
  int   acc [2] = '{0, 0};
  logic r0_last = 1'b0;
  logic o_open = 1'b0;
  logic o_sel = 1'b0;

  assign In0_valid = v[0];
  assign In1_valid = v[1];
  assign In0_data  = d[0];
  assign In1_data  = d[1];

  always #5 CLK = ~CLK;

  merge2_sync #(
    .FLIT_W (FW),
    .DEPTH  (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .In0_data  (In0_data),
    .In0_valid (In0_valid),
    .In0_ready (In0_ready),
    .In1_data  (In1_data),
    .In1_valid (In1_valid),
    .In1_ready (In1_ready),
    .Out_data  (Out_data),
    .Out_sel   (Out_sel),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h",
               name, act, exp);
    end
  endtask

  task automatic add_flit(input int s, input logic [FW-1:0] f);
    pend[s].push_back(f);
    expq[s].push_back(f);
  endtask

  task automatic add_pkt(input int s);
    int len;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++)
      add_flit(s, {(i == len - 1), 8'($urandom)});
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(pend[0].size() == 0 && pend[1].size() == 0
             && occ == 0) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    check(name, 32'(n < budget), 1);
  endtask

  task automatic cmp_log(input string name, input int base,
                         input logic [FW:0] e [$]);
    check({name, "_len"}, log_q.size() - base, e.size());
    for (int i = 0; i < e.size(); i++)
      if (base + i < log_q.size())
        check(name, 32'(log_q[base + i]), 32'(e[i]));
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    @(posedge CLK);
  endtask

  // Driver: holds each flit until its handshake, gaps only between packets
  always begin
    @(negedge CLK);
    if (RESET) begin
      for (int s = 0; s < 2; s++) begin
        v[s] = 1'b0;
        hs[s] = 1'b0;
        open_in[s] = 1'b0;
        pend[s].delete();
      end
      Out_ready = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        if (hs[s]) begin
          v[s] = 1'b0;
          hs[s] = 1'b0;
          if (pend[s].size() > 0) void'(pend[s].pop_front());
        end
        if (!v[s] && pend[s].size() > 0 &&
            (open_in[s] || $urandom_range(0, 99) < vprob)) begin
          v[s] = 1'b1;
          d[s] = pend[s][0];
          open_in[s] = ~pend[s][0][FW-1];
        end
      end
      case (omode)
        0: Out_ready = 1'b1;
        1: Out_ready = 1'b0;
        default: Out_ready = ($urandom_range(0, 99) < 70);
      endcase
    end
    #4;
    hs[0] = v[0] && In0_ready;
    hs[1] = v[1] && In1_ready;
  end

  // Monitor: samples one time unit before each rising edge
  always begin
    @(negedge CLK);
    #4;
    cyc++;
    if (RESET) begin
      check("rst_out_valid", Out_valid, 0);
      check("rst_readies", {In1_ready, In0_ready}, 0);
      occ = 0;
      o_open = 1'b0;
      expq[0].delete();
      expq[1].delete();
    end else begin
      r0_last = In0_ready;
      check("ready_onehot", In0_ready && In1_ready, 0);
      check("out_valid_vs_occ", Out_valid, occ > 0);
      if (occ == DEPTH && !Out_ready)
        check("full_blocks_ready", In0_ready || In1_ready, 0);
      if (In1_ready) r1_cnt++;
      if (Out_valid && Out_ready) begin
        if (expq[Out_sel].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: actual sel=%0d data=%03h, required no flit",
                   Out_sel, Out_data);
        end else begin
          check(Out_sel ? "data_in1" : "data_in0",
                Out_data, expq[Out_sel].pop_front());
        end
        if (o_open) check("contiguity_sel", Out_sel, o_sel);
        o_open = ~Out_data[FW-1];
        o_sel = Out_sel;
        log_q.push_back({Out_sel, Out_data});
        log_c.push_back(cyc);
        occ--;
      end
      if (v[0] && In0_ready) begin occ++; acc[0]++; end
      if (v[1] && In1_ready) begin occ++; acc[1]++; end
      check("occupancy_bound", 32'(occ <= DEPTH), 1);
    end
  end

  initial begin : main
    logic [FW:0] e [$];
    int base, a0, n, r1;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_out_valid", Out_valid, 0);
    check("reset_out_data", Out_data, 0);
    check("reset_out_sel", Out_sel, 0);
    check("reset_in0_ready", In0_ready, 0);
    check("reset_in1_ready", In1_ready, 0);
    #1 RESET = 1'b0;
    @(posedge CLK);

    // Single source, 3-flit packet
    base = log_q.size();
    r1 = r1_cnt;
    add_flit(0, 9'h001);
    add_flit(0, 9'h002);
    add_flit(0, 9'h103);
    wait_idle("t1_drain", 50);
    e = '{10'h001, 10'h002, 10'h103};
    cmp_log("t1_seq", base, e);
    for (int i = 0; i < 2; i++)
      if (base + i + 1 < log_c.size())
        check("t1_back_to_back",
              log_c[base + i + 1] - log_c[base + i], 1);
    check("t1_in1_ready_low", r1_cnt - r1, 0);

    // Tie after reset: In0 wins first, then alternate
    do_reset();
    base = log_q.size();
    for (int i = 0; i < 4; i++) begin
      add_flit(0, 9'h1AA);
      add_flit(1, 9'h1BB);
    end
    wait_idle("t2_drain", 60);
    e = '{10'h1AA, 10'h3BB, 10'h1AA, 10'h3BB,
          10'h1AA, 10'h3BB, 10'h1AA, 10'h3BB};
    cmp_log("t2_alternate", base, e);

    // Packet lock on In1 while In0 arrives mid-packet
    base = log_q.size();
    a0 = acc[1];
    add_flit(1, 9'h0C1);
    add_flit(1, 9'h0C2);
    add_flit(1, 9'h0C3);
    add_flit(1, 9'h1C4);
    n = 0;
    while (acc[1] - a0 < 1 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    check("t3_first_accept", 32'(n < 20), 1);
    add_flit(0, 9'h1A0);
    wait_idle("t3_drain", 60);
    e = '{10'h2C1, 10'h2C2, 10'h2C3, 10'h3C4, 10'h1A0};
    cmp_log("t3_lock", base, e);

    // Backpressure: buffer fills to DEPTH, then drains in order
    omode = 1;
    base = log_q.size();
    a0 = acc[0];
    for (int i = 0; i < 5; i++) add_flit(0, 9'(16 + i));
    add_flit(0, 9'h115);
    repeat (5) @(posedge CLK);
    check("t4_accepted", acc[0] - a0, DEPTH);
    check("t4_in0_ready_low", r0_last, 0);
    omode = 0;
    wait_idle("t4_drain", 60);
    e = '{10'h010, 10'h011, 10'h012, 10'h013,
          10'h014, 10'h115};
    cmp_log("t4_order", base, e);

    // Reset in the middle of a buffered packet
    omode = 1;
    a0 = acc[0];
    add_flit(0, 9'h020);
    add_flit(0, 9'h021);
    add_flit(0, 9'h022);
    add_flit(0, 9'h123);
    n = 0;
    while (acc[0] - a0 < 2 && n < 20) begin
      @(posedge CLK);
      n++;
    end
    check("t5_two_accepted", 32'(n < 20), 1);
    #2;
    check("t5_prereset_valid", Out_valid, 1);
    RESET = 1'b1;
    #1;
    check("t5_async_out_valid", Out_valid, 0);
    check("t5_async_out_data", Out_data, 0);
    check("t5_async_out_sel", Out_sel, 0);
    check("t5_async_in0_ready", In0_ready, 0);
    check("t5_async_in1_ready", In1_ready, 0);
    repeat (2) @(posedge CLK);
    #2 RESET = 1'b0;
    omode = 0;
    @(posedge CLK);
    base = log_q.size();
    add_flit(1, 9'h031);
    add_flit(1, 9'h132);
    wait_idle("t5_drain", 40);
    e = '{10'h231, 10'h332};
    cmp_log("t5_after_reset", base, e);

    // Random soak on both sides
    vprob = 60;
    omode = 2;
    repeat (10000) begin
      @(posedge CLK);
      for (int s = 0; s < 2; s++)
        if (pend[s].size() < 6 && $urandom_range(0, 3) == 0)
          add_pkt(s);
    end
    omode = 0;
    wait_idle("soak_drain", 2000);
    check("soak_in0_all_out", expq[0].size(), 0);
    check("soak_in1_all_out", expq[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
